audio_event_detector_mc: RTL and testbench
==========================================

// Module: audio_event_detector_mc
// PURPOSE
//  Parametrised multi-channel successor of the single-channel audio AI core. Collects a window of
//  2**WIN_LOG2 samples per channel over a valid/ready stream. Computes per-channel abs-energy, peak
//  and zero-crossing count, then classifies each channel and reports the highest-threat channel.
//  Supports single-shot and continuous windowing, abort, and latched runtime thresholds.
// PARAMETERS
//  SAMPLE_W  16  signed sample width per channel (two's complement)
//  NUM_CH    2   number of channels, 1..8; packed ch0 in LSBs
//  WIN_LOG2  9   log2 of window length in samples per channel
//  ACC_W     SAMPLE_W-1+WIN_LOG2  energy accumulator width (localparam, derived)
// PORTS
//  clk               in   1               clock
//  rst_n             in   1               async active-low reset
//  s_sample          in   NUM_CH*SAMPLE_W one sample per channel, all channels per beat
//  s_valid           in   1               sample beat valid
//  s_ready           out  1               beat accepted when s_valid&s_ready
//  start             in   1               begin analysis (sampled in IDLE only)
//  abort             in   1               cancel current window
//  cfg_continuous    in   1               1: re-arm automatically after each window
//  cfg_energy_thr    in   ACC_W           energy threshold (latched at start)
//  cfg_zc_thr        in   WIN_LOG2        zero-crossing threshold (latched at start)
//  result_class      out  2               0 normal, 1 high energy, 2 high zero-crossing
//  result_threat     out  8               10 / 90 / 85
//  result_channel    out  3               winning channel index
//  result_energy     out  ACC_W           winning channel energy
//  result_peak       out  SAMPLE_W-1      winning channel peak |x|
//  done              out  1               one-cycle pulse, results valid/updated
//  busy              out  1               high in any state except IDLE
//  windows_done      out  16              completed windows, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE. All outputs 0. All accumulators and counters 0.
//  FSM: IDLE -> COLLECT -> EVAL -> OUT, then IDLE, or COLLECT if continuous.
//  IDLE: start=1 latches the cfg_* inputs and clears accumulators, count and channel regs.
//   Next state COLLECT; busy=1 from the following cycle.
//  COLLECT: s_ready=1 (the only state with s_ready=1). Per accepted beat and per channel:
//   |x| = -x for negatives, and -2**(SAMPLE_W-1) saturates to 2**(SAMPLE_W-1)-1.
//   energy += |x|. peak = max(peak,|x|).
//   zc += 1 when sign bit differs from the previous accepted sample of the same channel.
//   The first sample of a window never counts as a crossing.
//   Gaps in s_valid are allowed, with no timeout.
//   Accepting beat 2**WIN_LOG2-1 (last) moves to EVAL.
//  EVAL: NUM_CH cycles, channel k evaluated in cycle k.
//   Channel class: energy>thr -> 1/threat 90; else zc>thr -> 2/threat 85; else 0/threat 10.
//   Comparisons are strict. A channel replaces the running best only if its threat is strictly
//   greater, so ties keep the lowest index.
//  OUT: one cycle. Registers best into the result_* outputs, pulses done, increments windows_done.
//   With cfg_continuous (latched at start) the next state is COLLECT with accumulators cleared and
//   thresholds kept; otherwise IDLE and busy=0.
//  Latency: last beat accepted at edge E0; done high after edge E0+NUM_CH+1 for exactly one cycle.
//   s_ready is low for NUM_CH+1 cycles between windows in continuous mode.
//  Results hold until the next done or reset.
//  abort=1 in COLLECT/EVAL: next state IDLE, no done, results and windows_done unchanged.
//   abort has priority over the last beat. abort in IDLE/OUT is ignored; OUT still completes.
//   To stop continuous mode, abort during the next COLLECT.
//  start while busy is ignored. Simultaneous start and abort in IDLE: start wins.
// TESTING (NUM_CH=2, WIN_LOG2=4, SAMPLE_W=16)
//  ch0=+1000 x16, ch1=0, thr_e=15000, thr_zc=4 -> class1, threat90, ch0, energy16000, peak1000;
//   done 3 cycles after the last beat.
//  ch0=0, ch1 alternating +100/-100 -> ch1 zc=15, energy1600 -> class2, threat85, ch1.
//  ch0=-32768 x16, thr_e=0x7FFFF -> peak 32767, energy 524272, class0, threat10, ch0.
//  s_ready=0 in IDLE; random s_valid gaps give the same results; start mid-COLLECT is ignored.
//  abort after beat 7 -> busy falls, no done, windows_done unchanged.
//   rst_n low mid-COLLECT -> all outputs 0 immediately.
//  cfg_continuous=1, 2 windows -> two done pulses 16+3 cycles apart (full-rate input);
//   windows_done=2; s_ready low for 3 cycles between windows.

Source files
------------

// File: rtl/audio_event_detector_mc.sv
// Multi-channel windowed audio event detector: per-channel energy, peak and
// zero-crossing statistics, per-channel classification and highest-threat pick.
module audio_event_detector_mc #(
  parameter int SAMPLE_W = 16,
  parameter int NUM_CH   = 2,
  parameter int WIN_LOG2 = 9,
  localparam int ACC_W   = SAMPLE_W - 1 + WIN_LOG2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*SAMPLE_W-1:0]   s_sample,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         cfg_continuous,
  input  logic [ACC_W-1:0]             cfg_energy_thr,
  input  logic [WIN_LOG2-1:0]          cfg_zc_thr,
  output logic [1:0]                   result_class,
  output logic [7:0]                   result_threat,
  output logic [2:0]                   result_channel,
  output logic [ACC_W-1:0]             result_energy,
  output logic [SAMPLE_W-2:0]          result_peak,
  output logic                         done,
  output logic                         busy,
  output logic [15:0]                  windows_done
);

  localparam int PK_W = SAMPLE_W - 1;
  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);
  localparam logic [WIN_LOG2-1:0] LAST_BEAT = {WIN_LOG2{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_EVAL,
    S_OUT
  } state_e;

  state_e state_q, state_d;

  logic [NUM_CH-1:0][ACC_W-1:0]    energy_q;
  logic [NUM_CH-1:0][PK_W-1:0]     peak_q;
  logic [NUM_CH-1:0][WIN_LOG2-1:0] zc_q;
  logic [NUM_CH-1:0]               sign_q;
  logic [WIN_LOG2-1:0]             cnt_q;
  logic [2:0]                      ch_q;

  logic [ACC_W-1:0]    thr_e_q;
  logic [WIN_LOG2-1:0] thr_zc_q;
  logic                cont_q;

  logic [1:0]       best_cls_q;
  logic [7:0]       best_thr_q;
  logic [2:0]       best_ch_q;
  logic [ACC_W-1:0] best_e_q;
  logic [PK_W-1:0]  best_pk_q;

  logic [1:0]       res_cls_q;
  logic [7:0]       res_thr_q;
  logic [2:0]       res_ch_q;
  logic [ACC_W-1:0] res_e_q;
  logic [PK_W-1:0]  res_pk_q;
  logic             done_q;
  logic [15:0]      wins_q;

  logic arm, clr, accept, eval_en, out_en;

  logic [NUM_CH-1:0][SAMPLE_W-1:0] neg;
  logic [NUM_CH-1:0][PK_W-1:0]     mag;
  logic [NUM_CH-1:0]               sgn;

  // Magnitude with -2**(SAMPLE_W-1) clamped to the largest positive value
  always_comb begin
    neg = '0;
    mag = '0;
    sgn = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sgn[k] = s_sample[k*SAMPLE_W + SAMPLE_W - 1];
      neg[k] = {SAMPLE_W{1'b0}} - s_sample[k*SAMPLE_W +: SAMPLE_W];
      if (!sgn[k]) begin
        mag[k] = s_sample[k*SAMPLE_W +: PK_W];
      end else if (neg[k][SAMPLE_W-1]) begin
        mag[k] = {PK_W{1'b1}};
      end else begin
        mag[k] = neg[k][PK_W-1:0];
      end
    end
  end

  logic [ACC_W-1:0]    sel_e;
  logic [PK_W-1:0]     sel_pk;
  logic [WIN_LOG2-1:0] sel_zc;

  always_comb begin
    sel_e  = '0;
    sel_pk = '0;
    sel_zc = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == 3'(k)) begin
        sel_e  = energy_q[k];
        sel_pk = peak_q[k];
        sel_zc = zc_q[k];
      end
    end
  end

  logic [1:0] cls_c;
  logic [7:0] thr_c;

  always_comb begin
    cls_c = 2'd0;
    thr_c = 8'd10;
    priority case (1'b1)
      (sel_e > thr_e_q): begin
        cls_c = 2'd1;
        thr_c = 8'd90;
      end
      (sel_zc > thr_zc_q): begin
        cls_c = 2'd2;
        thr_c = 8'd85;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    arm     = 1'b0;
    clr     = 1'b0;
    accept  = 1'b0;
    eval_en = 1'b0;
    out_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          arm     = 1'b1;
          clr     = 1'b1;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (s_valid) begin
          accept = 1'b1;
          if (cnt_q == LAST_BEAT) state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          eval_en = 1'b1;
          if (ch_q == LAST_CH) state_d = S_OUT;
        end
      end
      S_OUT: begin
        out_en  = 1'b1;
        clr     = cont_q;
        state_d = cont_q ? S_COLLECT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_e_q  <= '0;
      thr_zc_q <= '0;
      cont_q   <= 1'b0;
    end else if (arm) begin
      thr_e_q  <= cfg_energy_thr;
      thr_zc_q <= cfg_zc_thr;
      cont_q   <= cfg_continuous;
    end
  end

  // First beat of a window (cnt_q==0) never counts as a crossing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      energy_q <= '0;
      peak_q   <= '0;
      zc_q     <= '0;
      sign_q   <= '0;
      cnt_q    <= '0;
    end else if (clr) begin
      energy_q <= '0;
      peak_q   <= '0;
      zc_q     <= '0;
      sign_q   <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      for (int k = 0; k < NUM_CH; k++) begin
        energy_q[k] <= energy_q[k] + {{WIN_LOG2{1'b0}}, mag[k]};
        if (mag[k] > peak_q[k]) peak_q[k] <= mag[k];
        if (cnt_q != '0 && sgn[k] != sign_q[k]) begin
          zc_q[k] <= zc_q[k] + WIN_LOG2'(1);
        end
      end
      sign_q <= sgn;
      cnt_q  <= cnt_q + WIN_LOG2'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q       <= '0;
      best_cls_q <= '0;
      best_thr_q <= '0;
      best_ch_q  <= '0;
      best_e_q   <= '0;
      best_pk_q  <= '0;
    end else if (clr) begin
      ch_q       <= '0;
      best_cls_q <= '0;
      best_thr_q <= '0;
      best_ch_q  <= '0;
      best_e_q   <= '0;
      best_pk_q  <= '0;
    end else if (eval_en) begin
      ch_q <= ch_q + 3'd1;
      if (thr_c > best_thr_q) begin
        best_cls_q <= cls_c;
        best_thr_q <= thr_c;
        best_ch_q  <= ch_q;
        best_e_q   <= sel_e;
        best_pk_q  <= sel_pk;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cls_q <= '0;
      res_thr_q <= '0;
      res_ch_q  <= '0;
      res_e_q   <= '0;
      res_pk_q  <= '0;
      done_q    <= 1'b0;
      wins_q    <= '0;
    end else begin
      done_q <= out_en;
      if (out_en) begin
        res_cls_q <= best_cls_q;
        res_thr_q <= best_thr_q;
        res_ch_q  <= best_ch_q;
        res_e_q   <= best_e_q;
        res_pk_q  <= best_pk_q;
        wins_q    <= wins_q + 16'd1;
      end
    end
  end

  assign s_ready        = (state_q == S_COLLECT);
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign windows_done   = wins_q;
  assign result_class   = res_cls_q;
  assign result_threat  = res_thr_q;
  assign result_channel = res_ch_q;
  assign result_energy  = res_e_q;
  assign result_peak    = res_pk_q;

endmodule

// File: tb/tb_audio_event_detector_mc.sv
// Randomised bench for audio_event_detector_mc against a window-level
// behavioural model, plus hand-computed directed expectations.
module tb_audio_event_detector_mc;
  localparam int SW  = 16;
  localparam int NC  = 2;
  localparam int WL  = 4;
  localparam int AW  = SW - 1 + WL;
  localparam int WIN = 1 << WL;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NC*SW-1:0] s_sample;
  logic             s_valid, s_ready;
  logic             start, abort, cfg_continuous;
  logic [AW-1:0]    cfg_energy_thr;
  logic [WL-1:0]    cfg_zc_thr;
  logic [1:0]       result_class;
  logic [7:0]       result_threat;
  logic [2:0]       result_channel;
  logic [AW-1:0]    result_energy;
  logic [SW-2:0]    result_peak;
  logic             done, busy;
  logic [15:0]      windows_done;

  audio_event_detector_mc #(
    .SAMPLE_W(SW),
    .NUM_CH  (NC),
    .WIN_LOG2(WL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_sample      (s_sample),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .start         (start),
    .abort         (abort),
    .cfg_continuous(cfg_continuous),
    .cfg_energy_thr(cfg_energy_thr),
    .cfg_zc_thr    (cfg_zc_thr),
    .result_class  (result_class),
    .result_threat (result_threat),
    .result_channel(result_channel),
    .result_energy (result_energy),
    .result_peak   (result_peak),
    .done          (done),
    .busy          (busy),
    .windows_done  (windows_done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  logic [15:0] w0 [WIN];
  logic [15:0] w1 [WIN];

  // Window-level reference model
  bit          m_busy = 0, m_coll = 0, m_cont = 0;
  int          m_wait = 0, m_n = 0;
  logic [AW-1:0] m_te = '0;
  logic [WL-1:0] m_tz = '0;
  int          smp [NC][WIN];
  int          e_cls = 0, e_thr = 0, e_ch = 0, e_en = 0, e_pk = 0;
  bit          e_done = 0;
  logic [15:0] e_wd = '0;

  function automatic void eval_win();
    int best_t;
    best_t = -1;
    for (int k = 0; k < NC; k++) begin
      int en, pk, zc, a, c, t;
      en = 0; pk = 0; zc = 0;
      for (int i = 0; i < WIN; i++) begin
        a = (smp[k][i] < 0) ? -smp[k][i] : smp[k][i];
        if (a > 32767) a = 32767;
        en += a;
        if (a > pk) pk = a;
        if (i > 0 && ((smp[k][i] < 0) != (smp[k][i-1] < 0))) zc++;
      end
      if (en > int'(m_te))      begin c = 1; t = 90; end
      else if (zc > int'(m_tz)) begin c = 2; t = 85; end
      else                      begin c = 0; t = 10; end
      if (t > best_t) begin
        best_t = t;
        e_cls = c; e_thr = t; e_ch = k; e_en = en; e_pk = pk;
      end
    end
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_coll = 0; m_wait = 0; m_n = 0;
      e_cls = 0; e_thr = 0; e_ch = 0; e_en = 0; e_pk = 0;
      e_done = 0; e_wd = '0;
    end else begin
      e_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_coll = 1; m_n = 0;
          m_cont = cfg_continuous;
          m_te = cfg_energy_thr;
          m_tz = cfg_zc_thr;
        end
      end else if (m_coll) begin
        if (abort) begin
          m_busy = 0; m_coll = 0;
        end else if (s_valid) begin
          for (int k = 0; k < NC; k++)
            smp[k][m_n] = int'($signed(s_sample[k*SW +: SW]));
          m_n++;
          if (m_n == WIN) begin
            m_coll = 0;
            m_wait = NC + 1;
          end
        end
      end else if (m_wait > 1) begin
        if (abort) m_busy = 0;
        else m_wait--;
      end else begin
        eval_win();
        e_done = 1;
        e_wd = e_wd + 16'd1;
        if (m_cont) begin m_coll = 1; m_n = 0; end
        else m_busy = 0;
      end
    end
  end

  bit cmp_en = 0;
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("busy",    busy,           m_busy);
      chk("s_ready", s_ready,        m_busy && m_coll);
      chk("done",    done,           e_done);
      chk("wins",    windows_done,   e_wd);
      chk("class",   result_class,   e_cls);
      chk("threat",  result_threat,  e_thr);
      chk("channel", result_channel, e_ch);
      chk("energy",  result_energy,  e_en);
      chk("peak",    result_peak,    e_pk);
    end
  end

  int cyc = 0;
  int donecyc [$];
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(negedge clk);
    if (done) donecyc.push_back(cyc);
  end

  task automatic do_start(input bit cont, input int te, input int tz);
    start = 1'b1;
    cfg_continuous = cont;
    cfg_energy_thr = AW'(te);
    cfg_zc_thr = WL'(tz);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_window(input int nb, input int gap, input bit poke,
                             output int stalls);
    int i, guard;
    bit acc;
    i = 0; guard = 0; stalls = 0;
    while (i < nb) begin
      s_valid = ($urandom_range(0, 99) >= gap);
      s_sample = {w1[i], w0[i]};
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        cfg_energy_thr = AW'($urandom);
        cfg_zc_thr = WL'($urandom);
        cfg_continuous = 1'($urandom);
      end
      acc = s_valid && s_ready;
      if (s_valid && !s_ready) stalls++;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
      if (guard > 2000) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    s_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 1, 0);
  endtask

  function automatic logic [15:0] rnd_s();
    case ($urandom_range(0, 9))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, st, st1, seen;
    rst_n = 1'b0;
    s_sample = '0; s_valid = 0; start = 0; abort = 0;
    cfg_continuous = 0; cfg_energy_thr = '0; cfg_zc_thr = '0;
    repeat (3) @(posedge clk);
    cmp_en = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_energy", result_energy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", s_ready, 0);

    for (int i = 0; i < WIN; i++) begin w0[i] = 16'd1000; w1[i] = 16'd0; end
    do_start(0, 15000, 4);
    send_window(WIN, 0, 0, st);
    wait_done(lat);
    chk("t1_latency", lat, 3);
    chk("t1_class", result_class, 1);
    chk("t1_threat", result_threat, 90);
    chk("t1_ch", result_channel, 0);
    chk("t1_energy", result_energy, 16000);
    chk("t1_peak", result_peak, 1000);
    chk("t1_busy", busy, 0);

    for (int i = 0; i < WIN; i++) begin
      w0[i] = 16'd0;
      w1[i] = (i % 2 == 0) ? 16'd100 : 16'hFF9C;
    end
    do_start(0, 15000, 4);
    send_window(WIN, 0, 0, st);
    wait_done(lat);
    chk("t2_class", result_class, 2);
    chk("t2_threat", result_threat, 85);
    chk("t2_ch", result_channel, 1);
    chk("t2_energy", result_energy, 1600);

    for (int i = 0; i < WIN; i++) begin w0[i] = 16'h8000; w1[i] = 16'd0; end
    do_start(0, 'h7FFFF, 4);
    send_window(WIN, 0, 0, st);
    wait_done(lat);
    chk("t3_peak", result_peak, 32767);
    chk("t3_energy", result_energy, 524272);
    chk("t3_class", result_class, 0);
    chk("t3_threat", result_threat, 10);
    chk("t3_ch", result_channel, 0);

    for (int i = 0; i < WIN; i++) begin w0[i] = 16'd1000; w1[i] = 16'd0; end
    do_start(0, 15000, 4);
    send_window(WIN, 40, 1, st);
    wait_done(lat);
    chk("t4_energy", result_energy, 16000);
    chk("t4_class", result_class, 1);
    chk("t4_wins", windows_done, 4);

    do_start(0, 15000, 4);
    send_window(8, 0, 0, st);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_wins", windows_done, 4);

    do_start(0, 15000, 4);
    send_window(5, 0, 0, st);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_wins", windows_done, 0);
    chk("rstmid_energy", result_energy, 0);
    chk("rstmid_class", result_class, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    donecyc.delete();
    for (int i = 0; i < WIN; i++) begin w0[i] = 16'd1000; w1[i] = rnd_s(); end
    do_start(1, 15000, 4);
    send_window(WIN, 0, 0, st);
    for (int i = 0; i < WIN; i++) begin w0[i] = rnd_s(); w1[i] = rnd_s(); end
    send_window(WIN, 0, 0, st1);
    wait_done(lat);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("cont_gap", st1, 3);
    chk("cont_pulses", donecyc.size(), 2);
    if (donecyc.size() == 2) chk("cont_spacing", donecyc[1] - donecyc[0], 19);
    chk("cont_wins", windows_done, 2);
    chk("cont_stopped", busy, 0);

    for (int r = 0; r < 25; r++) begin
      bit cont;
      cont = 1'($urandom_range(0, 3) == 0);
      for (int i = 0; i < WIN; i++) begin w0[i] = rnd_s(); w1[i] = rnd_s(); end
      do_start(cont, $urandom_range(0, 400000), $urandom_range(0, 15));
      send_window(WIN, $urandom_range(0, 60), 1'($urandom), st);
      if (cont) begin
        for (int i = 0; i < WIN; i++) begin w0[i] = rnd_s(); w1[i] = rnd_s(); end
        send_window(WIN, $urandom_range(0, 30), 0, st);
      end
      wait_done(lat);
      if (cont) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
